// File: rtl/load_store_unit_if.sv
// Core-request, response and data-memory bundle for load_store_unit.
// slave is the unit's side; master is the core/memory side.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wd, mem_we
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wd, mem_we
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte/half/word access to a word-addressed data memory.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 100
) (
  input logic                clk,
  input logic                rst,
  load_store_unit_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e      state_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wd_q;
  logic        mem_we_q;
  logic        req_err;
  logic        misalign;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    if (we) begin
      ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    end else begin
      ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b101);
    end
    return ok;
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'h0, b};
      3'b101:  r = {16'h0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Read-modify-write merge for SB/SH into the word captured in READ.
  function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] old, input logic [15:0] wd);
    logic [31:0] r;
    r = old;
    if (f3 == 3'b000) begin
      r[{off, 3'b000} +: 8] = wd[7:0];
    end else begin
      r[{off[1], 4'b0000} +: 16] = wd;
    end
    return r;
  endfunction

  always_comb begin
    misalign = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
               ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`endif
    req_err = !f3_legal(bus.req_we, bus.req_funct3) ||
              ({2'b00, bus.req_addr[31:2]} >= MEM_WORDS) || misalign;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      off_q        <= 2'b00;
      wdata_q      <= 16'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wd_q     <= 32'h0;
      mem_we_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            we_q       <= bus.req_we;
            funct3_q   <= bus.req_funct3;
            off_q      <= bus.req_addr[1:0];
            wdata_q    <= bus.req_wdata[15:0];
            mem_addr_q <= {2'b00, bus.req_addr[31:2]};
            if (req_err) begin
              state_q      <= StDone;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'h0;
            end else if (bus.req_we && (bus.req_funct3 == 3'b010)) begin
              state_q  <= StWrite;
              mem_we_q <= 1'b1;
              mem_wd_q <= bus.req_wdata;
            end else begin
              state_q <= StRead;
            end
          end
        end
        StRead: begin
          if (we_q) begin
            state_q  <= StWrite;
            mem_we_q <= 1'b1;
            mem_wd_q <= store_merge(funct3_q, off_q, bus.mem_rd, wdata_q);
          end else begin
            state_q      <= StDone;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= load_ext(funct3_q, off_q, bus.mem_rd);
          end
        end
        StWrite: begin
          state_q      <= StDone;
          mem_we_q     <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= 32'h0;
        end
        StDone: begin
          state_q      <= StIdle;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'h0;
          mem_addr_q   <= 32'h0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wd     = mem_wd_q;
  // Gated so a reset landing on the WRITE cycle cannot commit the store.
  assign bus.mem_we     = mem_we_q & ~rst;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural 128-word data memory.
module tb_load_store_unit;

  logic clk;
  logic rst;
  load_store_unit_if bus ();

  load_store_unit #(.MEM_WORDS(100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:127];
  int          we_count;
  logic [31:0] last_waddr;
  logic [31:0] last_wdata;
  logic        pl_we;
  logic [6:0]  pl_addr;
  logic [31:0] pl_data;

  assign bus.mem_rd = (bus.mem_addr < 32'd128) ? mem[bus.mem_addr[6:0]] : 32'h0;

  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[bus.mem_addr[6:0]] <= bus.mem_wd;
      we_count               <= we_count + 1;
      last_waddr             <= bus.mem_addr;
      last_wdata             <= bus.mem_wd;
    end else if (pl_we) begin
      mem[pl_addr] <= pl_data;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp;
  int   n_fail;

  task automatic preload(input logic [6:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // Issue one request and wait (bounded) for its response; no checking here.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rdata, output logic err,
                        output int lat, output int nwe);
    int w0;
    int guard;
    @(negedge clk);
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wd;
    w0 = we_count;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    rdata = 32'hx;
    err = 1'bx;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (bus.resp_valid) break;
    end
    if (!bus.resp_valid) begin
      n_cmp++;
      n_fail++;
      $display("FAIL resp_timeout: addr %h got no resp_valid, want one within 10 cycles", addr);
    end
    rdata = bus.resp_rdata;
    err = bus.resp_err;
    nwe = we_count - w0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp += 7;
    if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", bus.req_ready); end
    if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.resp_valid); end
    if (bus.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", bus.resp_rdata); end
    if (bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", bus.resp_err); end
    if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b want 0", bus.mem_we); end
    if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_maddr: got %h want 0", bus.mem_addr); end
    if (bus.mem_wd !== 32'h0) begin n_fail++; $display("FAIL rst_mwd: got %h want 0", bus.mem_wd); end
  endtask

  task automatic test_loads;
    logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] adrs [5] = '{32'h1, 32'h1, 32'h2, 32'h0, 32'h0};
    logic [31:0] exps [5] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h0000AABC,
                              32'h8899AABC};
    logic [31:0] rd;
    logic        er;
    int          lat, nwe;
    exp_t        e;
    preload(7'd0, 32'h8899AABC);
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back('{rdata: exps[i], err: 1'b0, lat: 2});
      do_req(1'b0, f3s[i], adrs[i], 32'h0, rd, er, lat, nwe);
      e = sb_q.pop_front();
      n_cmp += 4;
      if (rd !== e.rdata) begin n_fail++; $display("FAIL load%0d_rdata: got %h want %h", i, rd, e.rdata); end
      if (er !== e.err) begin n_fail++; $display("FAIL load%0d_err: got %b want %b", i, er, e.err); end
      if (lat != e.lat) begin n_fail++; $display("FAIL load%0d_lat: got %0d want %0d", i, lat, e.lat); end
      if (nwe != 0) begin n_fail++; $display("FAIL load%0d_nowrite: got %0d writes want 0", i, nwe); end
    end
  endtask

  task automatic test_stores;
    logic [2:0]  f3s  [3] = '{3'b010, 3'b001, 3'b000};
    logic [31:0] adrs [3] = '{32'h8, 32'hA, 32'h9};
    logic [31:0] wds  [3] = '{32'hDEADBEEF, 32'h00001234, 32'hFFFFFF55};
    logic [31:0] mws  [3] = '{32'hDEADBEEF, 32'h1234BEEF, 32'h123455EF};
    int          lats [3] = '{2, 3, 3};
    logic [31:0] rd;
    logic        er;
    int          lat, nwe;
    exp_t        e;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back('{rdata: 32'h0, err: 1'b0, lat: lats[i]});
      do_req(1'b1, f3s[i], adrs[i], wds[i], rd, er, lat, nwe);
      e = sb_q.pop_front();
      n_cmp += 6;
      if (rd !== e.rdata) begin n_fail++; $display("FAIL store%0d_rdata: got %h want %h", i, rd, e.rdata); end
      if (er !== e.err) begin n_fail++; $display("FAIL store%0d_err: got %b want %b", i, er, e.err); end
      if (lat != e.lat) begin n_fail++; $display("FAIL store%0d_lat: got %0d want %0d", i, lat, e.lat); end
      if (nwe != 1) begin n_fail++; $display("FAIL store%0d_pulses: got %0d want 1", i, nwe); end
      if (last_waddr !== 32'd2) begin n_fail++; $display("FAIL store%0d_waddr: got %h want 2", i, last_waddr); end
      if (last_wdata !== mws[i]) begin n_fail++; $display("FAIL store%0d_wd: got %h want %h", i, last_wdata, mws[i]); end
    end
  endtask

  task automatic test_errors;
    logic        wes  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0]  f3s  [4] = '{3'b010, 3'b011, 3'b100, 3'b010};
    logic [31:0] adrs [4] = '{32'd400, 32'h4, 32'h4, 32'd400};
    logic [31:0] rd;
    logic        er;
    int          lat, nwe;
    exp_t        e;
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back('{rdata: 32'h0, err: 1'b1, lat: 1});
      do_req(wes[i], f3s[i], adrs[i], 32'hCAFEF00D, rd, er, lat, nwe);
      e = sb_q.pop_front();
      n_cmp += 4;
      if (rd !== e.rdata) begin n_fail++; $display("FAIL err%0d_rdata: got %h want %h", i, rd, e.rdata); end
      if (er !== e.err) begin n_fail++; $display("FAIL err%0d_err: got %b want %b", i, er, e.err); end
      if (lat != e.lat) begin n_fail++; $display("FAIL err%0d_lat: got %0d want %0d", i, lat, e.lat); end
      if (nwe != 0) begin n_fail++; $display("FAIL err%0d_nowrite: got %0d writes want 0", i, nwe); end
    end
  endtask

  task automatic test_misalign;
    logic [2:0]  f3s  [2] = '{3'b010, 3'b001};
    logic [31:0] adrs [2] = '{32'h2, 32'h1};
`ifdef LSU_MISALIGN_TRAP_EN
    logic [31:0] exps [2] = '{32'h0, 32'h0};
    logic        errs [2] = '{1'b1, 1'b1};
    int          lats [2] = '{1, 1};
`else
    logic [31:0] exps [2] = '{32'h8899AABC, 32'hFFFFAABC};
    logic        errs [2] = '{1'b0, 1'b0};
    int          lats [2] = '{2, 2};
`endif
    logic [31:0] rd;
    logic        er;
    int          lat, nwe;
    exp_t        e;
    for (int i = 0; i < 2; i++) begin
      sb_q.push_back('{rdata: exps[i], err: errs[i], lat: lats[i]});
      do_req(1'b0, f3s[i], adrs[i], 32'h0, rd, er, lat, nwe);
      e = sb_q.pop_front();
      n_cmp += 3;
      if (rd !== e.rdata) begin n_fail++; $display("FAIL mis%0d_rdata: got %h want %h", i, rd, e.rdata); end
      if (er !== e.err) begin n_fail++; $display("FAIL mis%0d_err: got %b want %b", i, er, e.err); end
      if (lat != e.lat) begin n_fail++; $display("FAIL mis%0d_lat: got %0d want %0d", i, lat, e.lat); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd;
    logic        er;
    int          lat, nwe;
    exp_t        e;
    sb_q.push_back('{rdata: 32'h123455EF, err: 1'b0, lat: 2});
    sb_q.push_back('{rdata: 32'h00001234, err: 1'b0, lat: 2});
    do_req(1'b0, 3'b010, 32'h8, 32'h0, rd, er, lat, nwe);
    e = sb_q.pop_front();
    n_cmp += 2;
    if (rd !== e.rdata) begin n_fail++; $display("FAIL b2b0_rdata: got %h want %h", rd, e.rdata); end
    if (lat != e.lat) begin n_fail++; $display("FAIL b2b0_lat: got %0d want %0d", lat, e.lat); end
    // Immediately after DONE the unit must be idle again and the pulse gone.
    @(negedge clk);
    n_cmp += 2;
    if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_pulse: got %b want 0", bus.resp_valid); end
    if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", bus.req_ready); end
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b101; bus.req_addr = 32'hA;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (bus.resp_valid) break;
    end
    e = sb_q.pop_front();
    n_cmp += 2;
    if (bus.resp_rdata !== e.rdata) begin n_fail++; $display("FAIL b2b1_rdata: got %h want %h", bus.resp_rdata, e.rdata); end
    if (lat != e.lat) begin n_fail++; $display("FAIL b2b1_lat: got %0d want %0d", lat, e.lat); end
  endtask

  task automatic test_reset_mid_write;
    int seen;
    int w0;
    preload(7'd4, 32'h11223344);
    @(negedge clk);
    w0 = we_count;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h10; bus.req_wdata = 32'h000000AB;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp += 1;
    if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL rmw_write_cycle: mem_we got %b want 1", bus.mem_we); end
    rst = 1'b1;
    #1;
    n_cmp += 1;
    if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rmw_gate: mem_we got %b want 0", bus.mem_we); end
    @(negedge clk);
    rst = 1'b0;
    n_cmp += 1;
    if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rmw_ready: got %b want 1", bus.req_ready); end
    seen = 0;
    repeat (4) begin
      if (bus.resp_valid) seen++;
      @(negedge clk);
    end
    n_cmp += 3;
    if (seen != 0) begin n_fail++; $display("FAIL rmw_noresp: got %0d resp_valid cycles want 0", seen); end
    if (we_count != w0) begin n_fail++; $display("FAIL rmw_nowrite: got %0d writes want 0", we_count - w0); end
    if (mem[4] !== 32'h11223344) begin n_fail++; $display("FAIL rmw_mem: got %h want 11223344", mem[4]); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    we_count = 0;
    last_waddr = 32'h0;
    last_wdata = 32'h0;
    pl_we = 1'b0;
    pl_addr = 7'd0;
    pl_data = 32'h0;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_misalign();
    test_back_to_back();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 100, number of 32-bit words in the data memory.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  core request present.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  input  3  RV32I size/sign code.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata  output  32  load result, extended per funct3.
REQ-012 SHALL have port resp_err  output  1  access rejected; valid with resp_valid.
REQ-013 SHALL have port mem_addr  output  32  word index to data memory.
REQ-014 SHALL have port mem_wd  output  32  full-word write data to memory.
REQ-015 SHALL have port mem_we  output  1  memory write enable.
REQ-016 SHALL have port mem_rd  input  32  memory combinational read data for mem_addr.

Function
REQ-017 SHALL accept a request on a rising edge where req_valid and req_ready are both 1, registering we, funct3, addr, wdata.
REQ-018 SHALL drive req_ready = 1 only in state IDLE.
REQ-019 SHALL implement states IDLE, READ, WRITE, DONE.
REQ-020 SHALL, on acceptance, transition IDLE->DONE with error if rejected, IDLE->WRITE for SW, otherwise IDLE->READ.
REQ-021 SHALL transition READ->WRITE for SB/SH and READ->DONE for loads, capturing mem_rd at the READ edge.
REQ-022 SHALL transition WRITE->DONE and DONE->IDLE unconditionally.
REQ-023 SHALL set legal codes: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; any other code sets resp_err.
REQ-024 SHALL drive mem_addr = {2'b00, addr[31:2]} from the registered address in all non-IDLE states, 0 in IDLE.
REQ-025 SHALL set resp_err when addr[31:2] >= MEM_WORDS; no memory read or write occurs.
REQ-026 SHALL assert mem_we only in WRITE, gated by !rst, for exactly one cycle per store.
REQ-027 SHALL drive mem_wd = wdata for SW; for SB/SH, the captured word with only the addressed byte (addr[1:0]) or halfword (addr[1]) replaced.
REQ-028 SHALL select load byte/halfword by addr[1:0]/addr[1]; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-029 SHALL hold resp_valid = 1 for exactly the DONE cycle, with resp_rdata valid for loads and 0 for stores/errors.
REQ-030 SHALL have latency from acceptance edge to resp_valid: error 1 cycle, SW 2, loads 2, SB/SH 3.
REQ-031 SHALL ignore req_valid while not IDLE; back-to-back requests are accepted in the cycle after DONE.

Reset
REQ-032 SHALL, with rst high at a rising edge, enter IDLE and clear all registers; req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wd=0.
REQ-033 SHALL abort an in-flight access when reset occurs mid-operation, with no memory write at that edge and no resp_valid.

Configuration
REQ-034 SHALL, with macro LSU_MISALIGN_TRAP_EN defined, reject a halfword with addr[0]=1 or a word with addr[1:0]!=0 via resp_err, with no memory access.
REQ-035 SHALL, with LSU_MISALIGN_TRAP_EN undefined, ignore low address bits below the access size and perform the aligned access without error.

Verification
REQ-036 SHALL verify a preloaded word 0 = 0x8899AABC: LB addr 0x1 -> resp_rdata 0xFFFFFFAA after 2 cycles; LBU -> 0x000000AA.
REQ-037 SHALL verify SW 0xDEADBEEF addr 0x8 -> one mem_we pulse with mem_addr 2, mem_wd 0xDEADBEEF, resp_valid 2 cycles after acceptance.
REQ-038 SHALL verify word 2 = 0xDEADBEEF followed by SH 0x1234 at addr 0xA -> mem_wd 0x1234BEEF, resp_valid 3 cycles after acceptance.
REQ-039 SHALL verify LW addr 400 (word 100, MEM_WORDS=100) -> resp_err=1 after 1 cycle, mem_we never asserted.
REQ-040 SHALL verify that with LSU_MISALIGN_TRAP_EN, LW addr 0x2 -> resp_err=1; without it -> resp_rdata = word 0, resp_err=0.
REQ-041 SHALL verify that rst asserted during the WRITE cycle of an SB -> no write, no resp_valid, and req_ready=1 on the next cycle.
